// File: rtl/fifo_controller.sv
// Head/tail/occupancy sequencer for an 8-entry register-file FIFO; drives write strobe/address and read strobe/address.
// Latency: we/re are combinational; pointers, count and ack/err status update on the request edge (status visible next cycle).
// Backpressure: writes when full and reads when empty are refused with a one-cycle err pulse; simultaneous wr/rd is ignored.
module fifo_controller #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              re,
    output logic [CNT_W-1:0]  data_count,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        INIT,
        NO_OP,
        WRITE,
        WR_ERROR,
        READ,
        RD_ERROR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [CNT_W-1:0]  count;

    logic wr_only;
    logic rd_only;

    assign wr_only = wr_en & ~rd_en;
    assign rd_only = rd_en & ~wr_en;

    // full/empty come from the registered count, so the strobes never see a glitching flag
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign we = wr_only & ~full  & ~reset;
    assign re = rd_only & ~empty & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (wr_only) begin
            if (full) begin
                state <= WR_ERROR;
            end else begin
                state <= WRITE;
                tail  <= tail + ADDR_W'(1);
                count <= count + CNT_W'(1);
            end
        end else if (rd_only) begin
            if (empty) begin
                state <= RD_ERROR;
            end else begin
                state <= READ;
                head  <= head + ADDR_W'(1);
                count <= count - CNT_W'(1);
            end
        end else begin
            state <= NO_OP;
        end
    end

    assign wr_addr    = tail;
    assign rd_addr    = head;
    assign data_count = count;

    assign wr_ack = (state == WRITE);
    assign wr_err = (state == WR_ERROR);
    assign rd_ack = (state == READ);
    assign rd_err = (state == RD_ERROR);

endmodule

// File: tb/tb_fifo_controller.sv
// Directed bench for fifo_controller: reset, fill, overflow, drain, underflow, simultaneous requests, reset mid-write.
module tb_fifo_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] wr_addr;
    logic       we;
    logic [2:0] rd_addr;
    logic       re;
    logic [3:0] data_count;
    logic       full;
    logic       empty;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;

    int passed = 0;
    int total  = 0;

    fifo_controller #(.ADDR_W(3), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_addr    (wr_addr),
        .we         (we),
        .rd_addr    (rd_addr),
        .re         (re),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    // observed register state: tail, head, count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    function automatic logic [15:0] regs();
        return {wr_addr, rd_addr, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err};
    endfunction

    task automatic drive(input logic w, input logic r, input logic rst);
        wr_en = w;
        rd_en = r;
        reset = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        exp = {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0000};
        total++;
        if (regs() !== exp) $display("FAIL reset_state got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (regs() !== exp) $display("FAIL post_reset_idle got=%h exp=%h", regs(), exp);
        else passed++;
    endtask

    task automatic test_fill();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            total++;
            if ({we, re, wr_addr} !== {1'b1, 1'b0, 3'(i)})
                $display("FAIL fill_strobe[%0d] got we=%b re=%b wa=%0d exp we=1 re=0 wa=%0d", i, we, re, wr_addr, i);
            else passed++;
            tick();
            exp = {3'(i + 1), 3'd0, 4'(i + 1), (i == 7), 1'b0, 4'b1000};
            total++;
            if (regs() !== exp) $display("FAIL fill_state[%0d] got=%h exp=%h", i, regs(), exp);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        drive(1'b1, 1'b0, 1'b0);
        total++;
        if (we !== 1'b0) $display("FAIL overflow_we got=%b exp=0", we);
        else passed++;
        tick();
        exp = {3'd0, 3'd0, 4'd8, 1'b1, 1'b0, 4'b0100};
        total++;
        if (regs() !== exp) $display("FAIL overflow_state got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        exp = {3'd0, 3'd0, 4'd8, 1'b1, 1'b0, 4'b0000};
        total++;
        if (regs() !== exp) $display("FAIL overflow_pulse_end got=%h exp=%h", regs(), exp);
        else passed++;
    endtask

    task automatic test_drain();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            total++;
            if ({we, re, rd_addr} !== {1'b0, 1'b1, 3'(i)})
                $display("FAIL drain_strobe[%0d] got we=%b re=%b ra=%0d exp we=0 re=1 ra=%0d", i, we, re, rd_addr, i);
            else passed++;
            tick();
            exp = {3'd0, 3'(i + 1), 4'(7 - i), 1'b0, (i == 7), 4'b0010};
            total++;
            if (regs() !== exp) $display("FAIL drain_state[%0d] got=%h exp=%h", i, regs(), exp);
            else passed++;
        end
        drive(1'b0, 1'b1, 1'b0);
        total++;
        if (re !== 1'b0) $display("FAIL underflow_re got=%b exp=0", re);
        else passed++;
        tick();
        exp = {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0001};
        total++;
        if (regs() !== exp) $display("FAIL underflow_state got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        exp = {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0000};
        total++;
        if (regs() !== exp) $display("FAIL underflow_pulse_end got=%h exp=%h", regs(), exp);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if ({we, re} !== 2'b00) $display("FAIL simul_strobes got we=%b re=%b exp we=0 re=0", we, re);
        else passed++;
        tick();
        exp = {3'd3, 3'd0, 4'd3, 1'b0, 1'b0, 4'b0000};
        total++;
        if (regs() !== exp) $display("FAIL simul_state got=%h exp=%h", regs(), exp);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        exp = {3'd5, 3'd0, 4'd5, 1'b0, 1'b0, 4'b1000};
        total++;
        if (regs() !== exp) $display("FAIL pre_reset_state got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b1, 1'b0, 1'b1);
        total++;
        if (we !== 1'b0) $display("FAIL reset_we got=%b exp=0", we);
        else passed++;
        tick();
        exp = {3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0000};
        total++;
        if (regs() !== exp) $display("FAIL reset_mid_state got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        exp = {3'd1, 3'd0, 4'd1, 1'b0, 1'b0, 4'b1000};
        total++;
        if (regs() !== exp) $display("FAIL after_reset_write got=%h exp=%h", regs(), exp);
        else passed++;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_reset_mid_write();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
